// File: rtl/mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl
//   Sequencer for one dot-product on an external MAC. After a start it clears
//   the MAC, streams operand addresses 0..len_m1 to the shared A/B operand
//   memories, enables MAC accumulation in step with the operand data, waits for
//   the pipeline to empty, captures the MAC result and offers it on a
//   valid/ready output.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   start, len_m1, fmt      request (sampled in IDLE only), length-1, number fmt
//   abort                   cancel whatever is in progress
//   busy                    high in every state except IDLE
//   mem_ren, mem_addr       operand memory read port (A and B share the address)
//   mem_a_data, mem_b_data  operands, valid the cycle after mem_ren
//   mac_a, mac_b            operands passed straight through to the MAC
//   mac_acc, mac_clr        MAC accumulate enable / MAC reset
//   mac_format              fmt latched at start (0 = 2's compl, 1 = sign-mag)
//   mac_out                 MAC accumulator value
//   res_data, res_valid,    result handshake
//   res_ready
//
// Result handshake: res_data/res_valid are held stable while res_valid=1 and
// res_ready=0; the result is consumed in the cycle where both are 1, and
// res_valid drops in the following cycle.
// -----------------------------------------------------------------------------
module mac_seq_ctrl #(
  parameter int bw      = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] len_m1,
  input  logic               fmt,
  input  logic               abort,
  output logic               busy,
  output logic               mem_ren,
  output logic [addr_bw-1:0] mem_addr,
  input  logic [bw-1:0]      mem_a_data,
  input  logic [bw-1:0]      mem_b_data,
  output logic [bw-1:0]      mac_a,
  output logic [bw-1:0]      mac_b,
  output logic               mac_acc,
  output logic               mac_clr,
  output logic               mac_format,
  input  logic [psum_bw-1:0] mac_out,
  output logic [psum_bw-1:0] res_data,
  output logic               res_valid,
  input  logic               res_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [addr_bw-1:0] K_ONE = {{(addr_bw-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_next;
  logic [addr_bw-1:0] r_k;
  logic [addr_bw-1:0] r_len_m1;
  logic               r_fmt;
  logic               r_iss_d1;    // issue valid, aligned with memory data
  logic               r_iss_d2;    // issue valid, aligned with MAC input register
  logic [1:0]         r_drain_cnt;
  logic [psum_bw-1:0] r_res_data;
  logic               r_clr_q;     // one-cycle MAC clear after abort or reset
  logic               w_issue;
  logic               w_last_issue;
  logic               w_capture;

  assign w_issue      = (r_state == S_RUN);
  // k is never incremented past len_m1, so it cannot wrap inside an operation
  assign w_last_issue = w_issue && (r_k == r_len_m1);
  assign w_capture    = (r_state == S_DRAIN) && (r_drain_cnt == 2'd2);

  assign mac_a      = mem_a_data;
  assign mac_b      = mem_b_data;
  assign mac_acc    = r_iss_d2;
  assign mac_format = r_fmt;
  assign res_data   = r_res_data;

  // Next state and state-decoded outputs
  always_comb begin
    w_next    = r_state;
    busy      = (r_state != S_IDLE);
    mem_ren   = 1'b0;
    mem_addr  = '0;
    res_valid = 1'b0;
    mac_clr   = reset || r_clr_q;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLR;
      S_CLR: begin
        mac_clr = 1'b1;
        w_next  = S_RUN;
      end
      S_RUN: begin
        mem_ren  = 1'b1;
        mem_addr = r_k;
        if (w_last_issue) w_next = S_DRAIN;
      end
      S_DRAIN: if (w_capture) w_next = S_DONE;
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // abort wins over everything, including a start seen in IDLE
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_len_m1    <= '0;
      r_fmt       <= 1'b0;
      r_iss_d1    <= 1'b0;
      r_iss_d2    <= 1'b0;
      r_drain_cnt <= 2'd0;
      r_res_data  <= '0;
      r_clr_q     <= 1'b1;
    end else begin
      r_state <= w_next;
      r_clr_q <= abort;

      if (abort) begin
        r_iss_d1 <= 1'b0;
        r_iss_d2 <= 1'b0;
      end else begin
        r_iss_d1 <= w_issue;
        r_iss_d2 <= r_iss_d1;
      end

      if (abort || (r_state == S_CLR) || w_last_issue) begin
        r_k <= '0;
      end else if (w_issue) begin
        r_k <= r_k + K_ONE;
      end

      if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 2'd1;
      end else begin
        r_drain_cnt <= 2'd0;
      end

      if ((r_state == S_IDLE) && start && !abort) begin
        r_len_m1 <= len_m1;
        r_fmt    <= fmt;
      end

      if (w_capture && !abort) begin
        r_res_data <= mac_out;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mac_seq_ctrl
//   Bench for mac_seq_ctrl with an operand-memory model (1-cycle read latency)
//   and a MAC model (input register, 16-bit wrapping accumulator, sign-magnitude
//   output when mac_format=1). Expected results come from a reference dot
//   product and are queued at start, then popped on the result handshake.
// -----------------------------------------------------------------------------
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  len_m1;
  logic        fmt;
  logic        abort;
  logic        busy;
  logic        mem_ren;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_a_data;
  logic [7:0]  mem_b_data;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic        mac_acc;
  logic        mac_clr;
  logic        mac_format;
  logic [15:0] mac_out;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready;

  mac_seq_ctrl #(.bw(8), .psum_bw(16), .addr_bw(4)) dut (
    .clk(clk), .reset(reset), .start(start), .len_m1(len_m1), .fmt(fmt),
    .abort(abort), .busy(busy), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_a_data(mem_a_data), .mem_b_data(mem_b_data), .mac_a(mac_a),
    .mac_b(mac_b), .mac_acc(mac_acc), .mac_clr(mac_clr),
    .mac_format(mac_format), .mac_out(mac_out), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- models ----------------
  logic [7:0]         mem_a [16];
  logic [7:0]         mem_b [16];
  logic [7:0]         ra;
  logic [7:0]         rb;
  logic signed [15:0] tb_acc;

  function automatic logic signed [15:0] op_val(input logic [7:0] x, input logic f);
    logic signed [15:0] m;
    m = {9'd0, x[6:0]};
    if (f) return x[7] ? -m : m;
    return {{8{x[7]}}, x};
  endfunction

  function automatic logic [15:0] sm_out(input logic signed [15:0] s, input logic f);
    logic signed [15:0] n;
    n = -s;
    if (f && s[15]) return {1'b1, n[14:0]};
    return s;
  endfunction

  always @(posedge clk) begin
    if (mem_ren) begin
      mem_a_data <= mem_a[mem_addr];
      mem_b_data <= mem_b[mem_addr];
    end
    ra <= mac_a;
    rb <= mac_b;
    if (mac_clr) tb_acc <= '0;
    else if (mac_acc) tb_acc <= tb_acc + op_val(ra, mac_format) * op_val(rb, mac_format);
  end

  assign mac_out = sm_out(tb_acc, mac_format);

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    logic [3:0]   len_m1;
    logic         fmt;
    logic [127:0] a_flat;
    logic [127:0] b_flat;
    logic [15:0]  exp_res;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [15:0] dot_ref(input vec_t v);
    logic signed [15:0] s;
    s = '0;
    for (int i = 0; i <= int'(v.len_m1); i++)
      s = s + op_val(v.a_flat[i*8 +: 8], v.fmt) * op_val(v.b_flat[i*8 +: 8], v.fmt);
    return sm_out(s, v.fmt);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_op(input vec_t v, input int hold);
    int n, first, acc_cnt, acc_first, acc_last, addr_exp;
    bit got;
    logic [15:0] captured;
    logic [15:0] exp_v;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = v.a_flat[i*8 +: 8];
      mem_b[i] = v.b_flat[i*8 +: 8];
    end
    @(posedge clk); #1;
    exp_q.push_back(v.exp_res);
    start = 1'b1; len_m1 = v.len_m1; fmt = v.fmt; res_ready = (hold == 0);
    n = 0; got = 1'b0; first = -1; acc_cnt = 0; acc_first = -1; acc_last = -1; addr_exp = 0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (n == 1) begin
        check("clr_cycle_mac_clr", mac_clr, 1);
        check("clr_cycle_format", mac_format, v.fmt);
      end
      if (n == 2) check("run_mac_clr_low", mac_clr, 0);
      if (mem_ren) begin
        check("mem_addr_order", mem_addr, addr_exp);
        addr_exp++;
      end
      if (mac_acc) begin
        if (acc_first < 0) acc_first = n;
        acc_last = n;
        acc_cnt++;
      end
      if (res_valid) begin
        got = 1'b1;
        first = n;
      end else begin
        @(posedge clk); #1;
        start = 1'b0;
        n++;
      end
    end
    if (!got) begin
      check("res_valid_timeout", 0, 1);
      return;
    end
    check("res_valid_latency", first, int'(v.len_m1) + 6);
    check("issue_count", addr_exp, int'(v.len_m1) + 1);
    check("mac_acc_count", acc_cnt, int'(v.len_m1) + 1);
    check("mac_acc_first", acc_first, 4);
    check("mac_acc_last", acc_last, int'(v.len_m1) + 4);
    captured = res_data;
    if (hold > 0) begin
      for (int h = 1; h < hold; h++) begin
        @(posedge clk); #1;
        start = 1'b1; len_m1 = 4'hf;
        @(negedge clk);
        check("stall_res_valid", res_valid, 1);
        check("stall_res_data", res_data, captured);
        check("stall_busy", busy, 1);
      end
      @(posedge clk); #1;
      res_ready = 1'b1; start = 1'b1;
      @(negedge clk);
    end
    check("handshake", res_valid && res_ready, 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      exp_v = exp_q.pop_front();
      check("res_data", res_data, exp_v);
    end
    @(posedge clk); #1;
    start = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    check("post_done_busy", busy, 0);
    check("post_done_res_valid", res_valid, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; len_m1 = '0; fmt = 1'b0; abort = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end

    // table: directed cases first, random ones filled from the reference model
    for (int i = 0; i < 6; i++) begin
      vecs[i].a_flat = '0; vecs[i].b_flat = '0;
    end
    vecs[0].len_m1 = 4'd3; vecs[0].fmt = 1'b0; vecs[0].exp_res = 16'd70;
    for (int i = 0; i < 4; i++) begin
      vecs[0].a_flat[i*8 +: 8] = 8'(i + 1);
      vecs[0].b_flat[i*8 +: 8] = 8'(i + 5);
    end
    vecs[1].len_m1 = 4'd1; vecs[1].fmt = 1'b1; vecs[1].exp_res = 16'h8002;
    vecs[1].a_flat[7:0] = 8'h83; vecs[1].a_flat[15:8] = 8'h02;
    vecs[1].b_flat[7:0] = 8'h04; vecs[1].b_flat[15:8] = 8'h05;
    vecs[2].len_m1 = 4'd15; vecs[2].fmt = 1'b0; vecs[2].exp_res = 16'd61456;
    for (int i = 0; i < 16; i++) begin
      vecs[2].a_flat[i*8 +: 8] = 8'd127;
      vecs[2].b_flat[i*8 +: 8] = 8'd127;
    end
    for (int i = 3; i < 6; i++) begin
      vecs[i].len_m1 = 4'($urandom_range(0, 15));
      vecs[i].fmt    = 1'($urandom_range(0, 1));
      for (int j = 0; j < 16; j++) begin
        vecs[i].a_flat[j*8 +: 8] = 8'($urandom_range(0, 255));
        vecs[i].b_flat[j*8 +: 8] = 8'($urandom_range(0, 255));
      end
      vecs[i].exp_res = dot_ref(vecs[i]);
    end

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_reset_mac_clr", mac_clr, 1);
    check("in_reset_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_mem_ren", mem_ren, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mac_acc", mac_acc, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_res_data", res_data, 0);
    check("reset_mac_clr", mac_clr, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_mac_clr", mac_clr, 0);

    // table-driven operations
    for (int i = 0; i < 6; i++) do_op(vecs[i], 0);

    // result held with res_ready low for 5 cycles, start pulses ignored
    do_op(vecs[0], 5);

    // abort together with start in the 2nd RUN cycle
    @(posedge clk); #1;
    start = 1'b1; len_m1 = 4'd3; fmt = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    check("abort_cycle_addr", mem_addr, 1);
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_mac_clr", mac_clr, 1);
    check("abort_mac_acc", mac_acc, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_mac_clr_1cyc", mac_clr, 0);
    seen = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (res_valid || busy) seen++;
    end
    check("abort_no_result", seen, 0);

    // reset pulsed in the 2nd DRAIN cycle (cycle 7 of a len_m1=3 op)
    for (int i = 0; i < 16; i++) begin mem_a[i] = 8'd9; mem_b[i] = 8'd9; end
    @(posedge clk); #1;
    start = 1'b1; len_m1 = 4'd3; fmt = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_drain_busy", busy, 0);
    check("rst_drain_mem_ren", mem_ren, 0);
    check("rst_drain_mem_addr", mem_addr, 0);
    check("rst_drain_mac_acc", mac_acc, 0);
    check("rst_drain_res_valid", res_valid, 0);
    check("rst_drain_res_data", res_data, 0);
    check("rst_drain_mac_clr", mac_clr, 1);
    seen = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("rst_drain_no_result", seen, 0);
    do_op(vecs[1], 0);
    do_op(vecs[3], 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard stop in case a wait above is never satisfied
  initial begin
    #200000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows, one per line:
- bw, 8: operand width.
- psum_bw, 16: partial-sum width.
- addr_bw, 4: operand memory address width; max vector length 2^addr_bw.
REQ-002 Ports (name, direction, width, meaning) SHALL be as follows; reset is reset, synchronous, active-high; clock is clk.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous active-high reset.
- start  in  1  request a dot-product; sampled only in IDLE.
- len_m1  in  addr_bw  vector length minus 1; latched with start.
- fmt  in  1  0 = 2's complement, 1 = sign-magnitude; latched with start.
- abort  in  1  cancel current operation.
- busy  out  1  high in every state except IDLE.
- mem_ren  out  1  operand memory read enable.
- mem_addr  out  addr_bw  operand memory read address (shared by A and B memories).
- mem_a_data  in  bw  A operand; valid the cycle after mem_ren.
- mem_b_data  in  bw  B operand; valid the cycle after mem_ren.
- mac_a  out  bw  combinational pass-through of mem_a_data.
- mac_b  out  bw  combinational pass-through of mem_b_data.
- mac_acc  out  1  MAC accumulate enable.
- mac_clr  out  1  MAC clear (drives the MAC reset pin).
- mac_format  out  1  latched fmt.
- mac_out  in  psum_bw  MAC accumulator output.
- res_data  out  psum_bw  captured result.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.

Function
REQ-003 The FSM SHALL have states IDLE, CLR, RUN, DRAIN, DONE.
REQ-004 IDLE SHALL go to CLR on start=1, latching len_m1 and fmt, and SHALL otherwise stay in IDLE.
REQ-005 CLR SHALL last exactly 1 cycle with mac_clr=1, then go to RUN with issue counter k=0.
REQ-006 RUN SHALL, in each cycle, assert mem_ren=1 with mem_addr=k, then increment k; after the cycle in which k==len_m1, it SHALL go to DRAIN.
REQ-007 A 2-stage issue-valid pipe SHALL be kept, and mac_acc SHALL equal the issue valid delayed by 2 cycles (1 cycle memory latency plus 1 cycle MAC input register).
REQ-008 DRAIN SHALL last exactly 3 cycles; in its last cycle, mac_out SHALL be captured into res_data, and the FSM SHALL then go to DONE.
REQ-009 DONE SHALL hold res_valid=1 and a stable res_data until res_ready=1; it SHALL leave on that handshake cycle to IDLE.
REQ-010 Latency SHALL be as follows: with start accepted in cycle 0, res_valid SHALL first be high in cycle len_m1+6; mac_acc SHALL be high in exactly cycles 4..len_m1+4, for len_m1+1 cycles total.
REQ-011 mac_format SHALL hold the latched fmt from CLR until the next accepted start.
REQ-012 When idle, outputs SHALL be driven as follows: mem_ren=0, mac_acc=0, mem_addr=0.
REQ-013 start SHALL be ignored outside IDLE, including DONE with res_ready=1 in the same cycle.
REQ-014 abort=1 SHALL move any state to IDLE in the next cycle, clear the pipe and res_valid, and assert mac_clr for that 1 cycle; abort SHALL beat start when both are high.
REQ-015 len_m1 = 2^addr_bw-1 SHALL issue all addresses 0..2^addr_bw-1, and k SHALL NOT wrap within an operation.

Reset
REQ-016 When reset=1, the block SHALL enter IDLE and clear k, the pipe, res_data, res_valid, busy, mem_ren and mac_acc to 0, and SHALL hold mac_clr=1.
REQ-017 Reset mid-operation SHALL discard the operation, and no res_valid SHALL follow.

Verification
REQ-018 The bench SHALL cover start with len_m1=3, fmt=0, A={1,2,3,4}, B={5,6,7,8} -> res_data=70 and res_valid first in cycle 9.
REQ-019 The bench SHALL cover fmt=1, len_m1=1, A={0x83,0x02}, B={0x04,0x05} (-3*4 + 2*5) -> internal psum -2 and res_data=0x8002.
REQ-020 The bench SHALL cover res_ready held low 5 cycles in DONE -> res_valid and res_data stable throughout, with start pulses ignored and busy=1.
REQ-021 The bench SHALL cover abort asserted in the 2nd RUN cycle together with start -> IDLE next cycle, mac_clr 1 cycle, and no res_valid.
REQ-022 The bench SHALL cover len_m1=15 with all operands 127 -> addresses 0..15 in order, 16 mac_acc cycles, and res_data=258064 mod 2^16 (wrap per MAC width).
REQ-023 The bench SHALL cover reset pulsed in DRAIN -> all outputs at reset values next cycle, and a subsequent start completes correctly.
